stopwatch_record_ctrl_57: RTL
=============================

# stopwatch_record_ctrl_57

Sequencing and arbitration controller for the stopwatch lap-record register file. Three requesters share the file's single write port and single read port: lap capture from the running stopwatch, record browsing from the key handler, and clear-all. The block queues their one-cycle request pulses and runs each access as a fixed-length transaction. It keeps the circular write pointer, the record count and the browse index. It registers the record read back for the display path.

## Interface
Parameters:
- DEPTH, 5, number of record slots (addresses 0..DEPTH-1)
- AW, 3, address/count width; must hold DEPTH

Ports:
- clk_50m_57  in  1  system clock, 50 MHz
- rst_n_57  in  1  reset, asynchronous, active-low
- browse_en_57  in  1  browse mode active (level)
- lap_req_57  in  1  one-cycle pulse: store current time as a new record
- next_req_57  in  1  one-cycle pulse: show next record (browse mode only)
- clear_req_57  in  1  one-cycle pulse: erase all records
- cur_sec_57 / cur_min_57 / cur_hour_57  in  7 each  live stopwatch time
- wr_e_57  out  1  register-file write enable
- wr_addr_57  out  AW  write address
- wr_sec_57 / wr_min_57 / wr_hour_57  out  7 each  write data
- rd_e_57  out  1  register-file read enable
- rd_addr_57  out  AW  read address
- rd_sec_57 / rd_min_57 / rd_hour_57  in  7 each  read data, valid the cycle after rd_e_57
- disp_sec_57 / disp_min_57 / disp_hour_57  out  7 each  record shown on the display
- disp_idx_57  out  AW  slot currently displayed
- rec_cnt_57  out  AW  number of valid records, 0..DEPTH
- busy_57  out  1  high when state != IDLE or any request is pending

## Operation
- **Reset.** All outputs, pointers, pending flags and latched data are 0. State is IDLE.
- **Pending flags.** Each request pulse sets its own flag: lap_pend, next_pend, clr_pend.
  - A lap pulse also latches cur_* into lap_data in the same edge.
  - A pulse that arrives while its flag is already set is dropped, and the latched data is not overwritten.
  - next_req_57 is ignored while browse_en_57 is 0.
  - When browse_en_57 goes low, next_pend is cleared.
- **Arbitration.** Evaluated only in IDLE. Fixed priority: clr_pend > lap_pend > next_pend, plus the auto-read. The chosen flag clears when its transaction starts.
- **State machine.**
  - IDLE -> CLR | WR | RD.
  - CLR: DEPTH cycles. wr_e_57=1, wr_addr_57 steps 0..DEPTH-1, data 0. On exit: wr_ptr=0, rec_cnt=0, disp_*=0, disp_idx=0. Goes to IDLE.
  - WR: one cycle. wr_e_57=1, wr_addr_57=wr_ptr, data=lap_data. wr_ptr advances DEPTH-1 -> 0 (wrap). rec_cnt increments and saturates at DEPTH. Goes to IDLE.
  - RD: one cycle. rd_e_57=1, rd_addr_57=target index. Goes to RD_WAIT.
  - RD_WAIT: one cycle. Captures rd_* into disp_* and sets disp_idx_57=target. Goes to IDLE.
- **Next target.** Target is (disp_idx+1) mod rec_cnt. If rec_cnt==0, the request is consumed with no read and the display is unchanged.
- **Auto-read.** On a rising edge of browse_en_57 with rec_cnt>0, an internal read of slot 0 is queued at next_pend priority.
- **Outputs outside transactions.** wr_e_57 and rd_e_57 are never high together. wr_*/rd_addr_57 are 0 outside their own states.
- **Hold.** disp_* holds its value outside RD_WAIT and CLR.

## Timing
- All outputs are registered. Cycle n is the cycle in which a request pulse is sampled.
- **Lap from idle.** wr_e_57 is high in cycle n+2. rec_cnt_57 updates in n+3.
- **Next from idle.** rd_e_57 is high in n+2. disp_* and disp_idx_57 are valid in n+4.
- **Clear from idle.** wr_e_57 is high in n+2..n+1+DEPTH. Counters reach 0 in n+2+DEPTH.
- **Back-to-back.** One IDLE cycle separates consecutive transactions.
- **Simultaneous pulses.** All are latched in the same cycle and served in priority order.
- **Lap during clear.** Written to slot 0 after CLR completes, with rec_cnt becoming 1.
- **Asynchronous reset mid-transaction.** The transaction aborts immediately, all outputs go to 0, and no partial state survives.

## Test plan
- **Reset.** Assert rst_n_57=0 mid-CLR -> all outputs 0 at once. After release: rec_cnt=0, busy=0.
- **Wrap.** 6 laps with cur time 0:0:1 .. 0:0:6 -> writes to addr 0,1,2,3,4,0 with sec 1..6. rec_cnt saturates at 5. Slot 0 holds sec 6.
- **Browse.** 3 records stored; raise browse_en -> disp = slot 0. Then 3 next pulses -> disp_idx 1, 2, 0, each valid 4 cycles after its pulse.
- **Empty and off modes.** next with rec_cnt=0 -> no rd_e_57, disp stays 0. next with browse_en=0 -> ignored, busy stays 0.
- **Simultaneous requests.** clear, lap and next pulsed in the same cycle -> 5 zero writes, then a lap write to addr 0, then a read of slot 0. rec_cnt ends at 1.
- **Lap during busy.** Lap pulse during CLR with cur=1:2:3 -> after clear, addr 0 written with 1:2:3. A second lap pulse while the first is pending -> dropped.

Source files
------------

// File: rtl/stopwatch_record_ctrl_57.sv
// Lap-record register-file sequencer. It queues lap, browse and clear requests
// and runs each one as a fixed-length write or read transaction on the file.
module stopwatch_record_ctrl_57 #(
    parameter int DEPTH = 5,
    parameter int AW    = 3
) (
    input  logic          clk_50m_57,
    input  logic          rst_n_57,
    input  logic          browse_en_57,
    input  logic          lap_req_57,
    input  logic          next_req_57,
    input  logic          clear_req_57,
    input  logic [6:0]    cur_sec_57,
    input  logic [6:0]    cur_min_57,
    input  logic [6:0]    cur_hour_57,
    output logic          wr_e_57,
    output logic [AW-1:0] wr_addr_57,
    output logic [6:0]    wr_sec_57,
    output logic [6:0]    wr_min_57,
    output logic [6:0]    wr_hour_57,
    output logic          rd_e_57,
    output logic [AW-1:0] rd_addr_57,
    input  logic [6:0]    rd_sec_57,
    input  logic [6:0]    rd_min_57,
    input  logic [6:0]    rd_hour_57,
    output logic [6:0]    disp_sec_57,
    output logic [6:0]    disp_min_57,
    output logic [6:0]    disp_hour_57,
    output logic [AW-1:0] disp_idx_57,
    output logic [AW-1:0] rec_cnt_57,
    output logic          busy_57,
    output logic [2:0]    state_dbg_57
);

    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] FULL_CNT  = AW'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR     = 3'd1,
        ST_WR      = 3'd2,
        ST_RD      = 3'd3,
        ST_RD_WAIT = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] clr_cnt_nxt;
    logic [AW-1:0] rd_tgt;
    logic [AW-1:0] rd_tgt_nxt;
    logic [AW-1:0] wr_ptr;
    logic          browse_q;

    // Requests are single-cycle pulses with no ready: a pulse is latched into
    // its pending flag, or dropped when that flag is already set.
    logic          lap_pend;
    logic          next_pend;
    logic          clr_pend;
    logic          auto_pend;
    logic          lap_pend_nxt;
    logic          next_pend_nxt;
    logic          clr_pend_nxt;
    logic          auto_pend_nxt;
    logic          take_lap;
    logic          take_next;
    logic          take_clr;
    logic          take_auto;

    logic [6:0]    lap_sec;
    logic [6:0]    lap_min;
    logic [6:0]    lap_hour;

    logic          wr_e_nxt;
    logic [AW-1:0] wr_addr_nxt;
    logic [6:0]    wr_sec_nxt;
    logic [6:0]    wr_min_nxt;
    logic [6:0]    wr_hour_nxt;
    logic          rd_e_nxt;
    logic [AW-1:0] rd_addr_nxt;

    logic [AW:0]   idx_inc;
    logic [AW-1:0] next_tgt;
    logic          browse_rise;

    assign state_dbg_57 = state;
    assign browse_rise  = browse_en_57 && !browse_q;

    // Browse advances circularly over the records actually stored.
    assign idx_inc  = {1'b0, disp_idx_57} + {{AW{1'b0}}, 1'b1};
    assign next_tgt = (idx_inc >= {1'b0, rec_cnt_57}) ? '0 : idx_inc[AW-1:0];

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        rd_tgt_nxt  = rd_tgt;
        take_lap    = 1'b0;
        take_next   = 1'b0;
        take_clr    = 1'b0;
        take_auto   = 1'b0;
        wr_e_nxt    = 1'b0;
        wr_addr_nxt = '0;
        wr_sec_nxt  = '0;
        wr_min_nxt  = '0;
        wr_hour_nxt = '0;
        rd_e_nxt    = 1'b0;
        rd_addr_nxt = '0;

        case (state)
            ST_IDLE: begin
                if (clr_pend) begin
                    take_clr    = 1'b1;
                    state_nxt   = ST_CLR;
                    clr_cnt_nxt = '0;
                    wr_e_nxt    = 1'b1;
                end else if (lap_pend) begin
                    take_lap    = 1'b1;
                    state_nxt   = ST_WR;
                    wr_e_nxt    = 1'b1;
                    wr_addr_nxt = wr_ptr;
                    wr_sec_nxt  = lap_sec;
                    wr_min_nxt  = lap_min;
                    wr_hour_nxt = lap_hour;
                end else if (auto_pend) begin
                    take_auto  = 1'b1;
                    state_nxt  = ST_RD;
                    rd_tgt_nxt = '0;
                    rd_e_nxt   = 1'b1;
                end else if (next_pend) begin
                    // With no records the request is simply consumed.
                    take_next = 1'b1;
                    if (rec_cnt_57 != '0) begin
                        state_nxt   = ST_RD;
                        rd_tgt_nxt  = next_tgt;
                        rd_e_nxt    = 1'b1;
                        rd_addr_nxt = next_tgt;
                    end
                end
            end
            ST_CLR: begin
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt = ST_IDLE;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_ONE;
                    wr_e_nxt    = 1'b1;
                    wr_addr_nxt = clr_cnt + ADDR_ONE;
                end
            end
            ST_WR:      state_nxt = ST_IDLE;
            ST_RD:      state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        lap_pend_nxt  = take_lap ? 1'b0 : (lap_pend || lap_req_57);
        clr_pend_nxt  = take_clr ? 1'b0 : (clr_pend || clear_req_57);
        next_pend_nxt = 1'b0;
        auto_pend_nxt = 1'b0;
        if (browse_en_57) begin
            next_pend_nxt = take_next ? 1'b0 : (next_pend || next_req_57);
            auto_pend_nxt = take_auto ? 1'b0
                          : (auto_pend || (browse_rise && rec_cnt_57 != '0));
        end
    end

    always_ff @(posedge clk_50m_57 or negedge rst_n_57) begin
        if (!rst_n_57) begin
            state      <= ST_IDLE;
            clr_cnt    <= '0;
            rd_tgt     <= '0;
            browse_q   <= 1'b0;
            lap_pend   <= 1'b0;
            next_pend  <= 1'b0;
            clr_pend   <= 1'b0;
            auto_pend  <= 1'b0;
            wr_e_57    <= 1'b0;
            wr_addr_57 <= '0;
            wr_sec_57  <= '0;
            wr_min_57  <= '0;
            wr_hour_57 <= '0;
            rd_e_57    <= 1'b0;
            rd_addr_57 <= '0;
            busy_57    <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_cnt    <= clr_cnt_nxt;
            rd_tgt     <= rd_tgt_nxt;
            browse_q   <= browse_en_57;
            lap_pend   <= lap_pend_nxt;
            next_pend  <= next_pend_nxt;
            clr_pend   <= clr_pend_nxt;
            auto_pend  <= auto_pend_nxt;
            wr_e_57    <= wr_e_nxt;
            wr_addr_57 <= wr_addr_nxt;
            wr_sec_57  <= wr_sec_nxt;
            wr_min_57  <= wr_min_nxt;
            wr_hour_57 <= wr_hour_nxt;
            rd_e_57    <= rd_e_nxt;
            rd_addr_57 <= rd_addr_nxt;
            busy_57    <= (state_nxt != ST_IDLE) || lap_pend_nxt || next_pend_nxt
                          || clr_pend_nxt || auto_pend_nxt;
        end
    end

    // Lap time is frozen at the pulse so a late write still stores the lap moment.
    always_ff @(posedge clk_50m_57 or negedge rst_n_57) begin
        if (!rst_n_57) begin
            lap_sec  <= '0;
            lap_min  <= '0;
            lap_hour <= '0;
        end else if (lap_req_57 && !lap_pend) begin
            lap_sec  <= cur_sec_57;
            lap_min  <= cur_min_57;
            lap_hour <= cur_hour_57;
        end
    end

    always_ff @(posedge clk_50m_57 or negedge rst_n_57) begin
        if (!rst_n_57) begin
            wr_ptr       <= '0;
            rec_cnt_57   <= '0;
            disp_sec_57  <= '0;
            disp_min_57  <= '0;
            disp_hour_57 <= '0;
            disp_idx_57  <= '0;
        end else begin
            if (state == ST_WR) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_ONE;
                if (rec_cnt_57 != FULL_CNT) begin
                    rec_cnt_57 <= rec_cnt_57 + ADDR_ONE;
                end
            end
            if (state == ST_CLR && clr_cnt == LAST_ADDR) begin
                wr_ptr       <= '0;
                rec_cnt_57   <= '0;
                disp_sec_57  <= '0;
                disp_min_57  <= '0;
                disp_hour_57 <= '0;
                disp_idx_57  <= '0;
            end
            if (state == ST_RD_WAIT) begin
                disp_sec_57  <= rd_sec_57;
                disp_min_57  <= rd_min_57;
                disp_hour_57 <= rd_hour_57;
                disp_idx_57  <= rd_tgt;
            end
        end
    end

endmodule
